prefetch_stream_engine: RTL and testbench

Parametrised, lane-scalable successor to the two-lane prefetcher engine. On a one-cycle trigger it walks a programmed descriptor, in either strided or indirect (index-gather) mode. It issues LANES-wide read requests to the cache and writes the returned words into the store buffer. It sits between the prefetch control logic, which supplies the descriptor, and the cache/store-buffer ports.

---
 rtl/prefetch_stream_engine.sv | 205 ++++++++++++++++++++
 tb/tb_prefetch_stream_engine.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_stream_engine.sv
// Descriptor-driven prefetch engine: walks a strided or index-gathered element list,
// issuing LANES-wide cache reads and writing the returned words into the store buffer.
module prefetch_stream_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic                      abort,
  input  logic                      mode,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [ADDR_W-1:0]         cfg_stride,
  input  logic [ADDR_W-1:0]         cfg_idx_base,
  input  logic [ADDR_W-1:0]         cfg_dst,
  input  logic [CNT_W-1:0]          cfg_count,
  output logic                      cache_data_req_o,
  output logic [LANES*ADDR_W-1:0]   cache_r_addr_o,
  input  logic                      wait_cache,
  input  logic                      cache_data_ready,
  input  logic [LANES*DATA_W-1:0]   cache_data_i,
  output logic [LANES-1:0]          strBufWren,
  output logic [LANES*ADDR_W-1:0]   w_addr_o,
  output logic [LANES*DATA_W-1:0]   w_data_o,
  input  logic                      wait_strBuf,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                outState
);

  // One spare bit so i can step past count without wrapping.
  localparam int unsigned IW = CNT_W + 1;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StReqIdx   = 4'd1,
    StWaitIdx  = 4'd2,
    StReqData  = 4'd3,
    StWaitData = 4'd4,
    StWrite    = 4'd5,
    StDone     = 4'd6
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic                      mode_q, mode_d;
  logic [ADDR_W-1:0]         base_q, base_d, stride_q, stride_d;
  logic [ADDR_W-1:0]         idx_base_q, idx_base_d, dst_q, dst_d;
  logic [CNT_W-1:0]          count_q, count_d;
  // Holds the gathered indices, then the data words of the same batch.
  logic [LANES*DATA_W-1:0]   cap_q, cap_d;

  logic                      req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic [LANES*ADDR_W-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
  logic [LANES*DATA_W-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]          wren_q, wren_d;

  logic [IW-1:0]             lane_i    [LANES];
  logic [ADDR_W-1:0]         lane_elem [LANES];
  logic [LANES-1:0]          lane_act;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    mode_d     = mode_q;
    base_d     = base_q;
    stride_d   = stride_q;
    idx_base_d = idx_base_q;
    dst_d      = dst_q;
    count_d    = count_q;
    cap_d      = cap_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          mode_d     = mode;
          base_d     = cfg_base;
          stride_d   = cfg_stride;
          idx_base_d = cfg_idx_base;
          dst_d      = cfg_dst;
          count_d    = cfg_count;
          i_d        = '0;
          if (cfg_count == '0) state_d = StDone;
          else                 state_d = mode ? StReqIdx : StReqData;
        end
      end
      StReqIdx:  if (!wait_cache) state_d = StWaitIdx;
      StWaitIdx: begin
        if (cache_data_ready) begin
          cap_d   = cache_data_i;
          state_d = StReqData;
        end
      end
      StReqData:  if (!wait_cache) state_d = StWaitData;
      StWaitData: begin
        if (cache_data_ready) begin
          cap_d   = cache_data_i;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!wait_strBuf) begin
          i_d = i_q + IW'(LANES);
          if (i_d >= {1'b0, count_q}) state_d = StDone;
          else                        state_d = mode_q ? StReqIdx : StReqData;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_i[l]    = i_d + IW'(l);
      lane_act[l]  = lane_i[l] < {1'b0, count_d};
      lane_elem[l] = ADDR_W'(lane_i[l]);
    end
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    req_d   = 1'b0;
    raddr_d = '0;
    wren_d  = '0;
    waddr_d = '0;
    wdata_d = '0;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    for (int l = 0; l < LANES; l++) begin
      case (state_d)
        StReqIdx: begin
          req_d = 1'b1;
          if (lane_act[l]) raddr_d[l*ADDR_W +: ADDR_W] = idx_base_d + (lane_elem[l] << 2);
        end
        StReqData: begin
          req_d = 1'b1;
          if (lane_act[l]) begin
            if (mode_d) raddr_d[l*ADDR_W +: ADDR_W] =
                base_d + (ADDR_W'(cap_d[l*DATA_W +: DATA_W]) << 2);
            else        raddr_d[l*ADDR_W +: ADDR_W] = base_d + lane_elem[l] * stride_d;
          end
        end
        StWrite: begin
          if (lane_act[l]) begin
            wren_d[l]                     = 1'b1;
            waddr_d[l*ADDR_W +: ADDR_W]   = dst_d + (lane_elem[l] << 2);
            wdata_d[l*DATA_W +: DATA_W]   = cap_d[l*DATA_W +: DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      i_q        <= '0;
      mode_q     <= 1'b0;
      base_q     <= '0;
      stride_q   <= '0;
      idx_base_q <= '0;
      dst_q      <= '0;
      count_q    <= '0;
      cap_q      <= '0;
      req_q      <= 1'b0;
      raddr_q    <= '0;
      wren_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      idx_base_q <= idx_base_d;
      dst_q      <= dst_d;
      count_q    <= count_d;
      cap_q      <= cap_d;
      req_q      <= req_d;
      raddr_q    <= raddr_d;
      wren_q     <= wren_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cache_data_req_o = req_q;
  assign cache_r_addr_o   = raddr_q;
  assign strBufWren       = wren_q;
  assign w_addr_o         = waddr_q;
  assign w_data_o         = wdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign outState         = state_q;

endmodule

// File: tb/tb_prefetch_stream_engine.sv
// Scoreboard bench for prefetch_stream_engine: a reference model queues expected reads and
// writes per descriptor; a negedge monitor checks each accepted transfer against the queue.
module tb_prefetch_stream_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int CW = 16;

  logic            clk, reset, trigger, abort, mode;
  logic [AW-1:0]   cfg_base, cfg_stride, cfg_idx_base, cfg_dst;
  logic [CW-1:0]   cfg_count;
  logic            cache_data_req_o, wait_cache, cache_data_ready, wait_strBuf;
  logic [L*AW-1:0] cache_r_addr_o, w_addr_o;
  logic [L*DW-1:0] cache_data_i, w_data_o;
  logic [L-1:0]    strBufWren;
  logic            busy, done;
  logic [3:0]      outState;

  prefetch_stream_engine #(.ADDR_W(AW), .DATA_W(DW), .LANES(L), .CNT_W(CW)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .trigger          (trigger),
    .abort            (abort),
    .mode             (mode),
    .cfg_base         (cfg_base),
    .cfg_stride       (cfg_stride),
    .cfg_idx_base     (cfg_idx_base),
    .cfg_dst          (cfg_dst),
    .cfg_count        (cfg_count),
    .cache_data_req_o (cache_data_req_o),
    .cache_r_addr_o   (cache_r_addr_o),
    .wait_cache       (wait_cache),
    .cache_data_ready (cache_data_ready),
    .cache_data_i     (cache_data_i),
    .strBufWren       (strBufWren),
    .w_addr_o         (w_addr_o),
    .w_data_o         (w_data_o),
    .wait_strBuf      (wait_strBuf),
    .busy             (busy),
    .done             (done),
    .outState         (outState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [L-1:0]    wren;
    logic [L*AW-1:0] addr;
    logic [L*DW-1:0] data;
  } wr_t;

  logic [L*AW-1:0] exp_rd[$];
  wr_t             exp_wr[$];
  int              vectors = 0;
  int              miscompares = 0;
  int              done_cnt = 0;
  logic [31:0]     idx_tbl [0:7];
  logic [31:0]     tb_idx_base = 32'h0;

  // Scoreboard monitor: a transfer is accepted on the coming edge when its stall is low.
  initial begin
    logic [L*AW-1:0] ea;
    wr_t             ew, gw;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (done) done_cnt++;
        if (cache_data_req_o && !wait_cache) begin
          vectors++;
          if (exp_rd.size() == 0) begin
            miscompares++;
            $display("FAIL rd_unexpected: got addr %h, required no request", cache_r_addr_o);
          end else begin
            ea = exp_rd.pop_front();
            if (cache_r_addr_o !== ea) begin
              miscompares++;
              $display("FAIL rd_addr: got %h, required %h", cache_r_addr_o, ea);
            end
          end
        end
        if (|strBufWren && !wait_strBuf) begin
          vectors++;
          gw = {strBufWren, w_addr_o, w_data_o};
          if (exp_wr.size() == 0) begin
            miscompares++;
            $display("FAIL wr_unexpected: got %h, required no write", gw);
          end else begin
            ew = exp_wr.pop_front();
            if (gw !== ew) begin
              miscompares++;
              $display("FAIL wr: got %h, required %h", gw, ew);
            end
          end
        end
      end
    end
  end

  // Cache model: ready one cycle after accept; index reads come from idx_tbl, data = addr+1.
  initial begin
    logic [L*AW-1:0] la;
    logic            is_idx;
    logic [31:0]     a, off;
    cache_data_ready = 1'b0;
    cache_data_i     = '0;
    forever begin
      @(negedge clk);
      if (reset && cache_data_req_o && !wait_cache) begin
        la     = cache_r_addr_o;
        is_idx = (outState == 4'd1);
        @(posedge clk);
        #1;
        for (int l = 0; l < L; l++) begin
          a   = la[l*AW +: AW];
          off = (a - tb_idx_base) >> 2;
          cache_data_i[l*DW +: DW] = is_idx ? idx_tbl[off[2:0]] : a + 32'd1;
        end
        cache_data_ready = 1'b1;
        @(posedge clk);
        #1;
        cache_data_ready = 1'b0;
        cache_data_i     = '0;
      end
    end
  end

  task automatic build_exp(input logic m, input logic [31:0] base, stride, idxb, dst,
                           input int cnt);
    logic [L*AW-1:0] ia, da;
    wr_t             w;
    logic [31:0]     d;
    for (int i = 0; i < cnt; i += L) begin
      ia = '0;
      da = '0;
      w  = '0;
      for (int l = 0; l < L; l++) begin
        if (i + l < cnt) begin
          ia[l*AW +: AW] = idxb + 32'((i + l) * 4);
          d = m ? base + (idx_tbl[i+l] << 2) : base + 32'(i + l) * stride;
          da[l*AW +: AW]      = d;
          w.wren[l]           = 1'b1;
          w.addr[l*AW +: AW]  = dst + 32'((i + l) * 4);
          w.data[l*DW +: DW]  = d + 32'd1;
        end
      end
      if (m) exp_rd.push_back(ia);
      exp_rd.push_back(da);
      exp_wr.push_back(w);
    end
  endtask

  // Called one step after an edge; returns one step after the edge that samples trigger.
  task automatic kick(input logic m, input logic [31:0] base, stride, idxb, dst,
                      input int cnt);
    mode         = m;
    cfg_base     = base;
    cfg_stride   = stride;
    cfg_idx_base = idxb;
    cfg_dst      = dst;
    cfg_count    = CW'(cnt);
    tb_idx_base  = idxb;
    build_exp(m, base, stride, idxb, dst, cnt);
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 1;
    while (!done && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_state(input logic [3:0] s, output logic hit);
    int n = 0;
    while (outState !== s && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    hit = (outState === s);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({cache_data_req_o, cache_r_addr_o, strBufWren, w_addr_o, w_data_o, busy, done,
         outState} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b wren=%b busy=%b done=%b state=%0d, required all 0",
               cache_data_req_o, strBufWren, busy, done, outState);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_strided;
    int n;
    int d0 = done_cnt;
    kick(1'b0, 32'h1000, 32'd8, 32'h0, 32'h2000, 4);
    vectors++;
    if (cache_data_req_o !== 1'b1 || cache_r_addr_o !== {32'h1008, 32'h1000}) begin
      miscompares++;
      $display("FAIL strided_first_req: got req=%b addr=%h, required 1 / %h",
               cache_data_req_o, cache_r_addr_o, {32'h1008, 32'h1000});
    end
    wait_done(50, n);
    vectors++;
    if (n != 7 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL strided_latency: got done at %0d (done=%b), required 7", n, done);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1 || exp_rd.size() != 0
        || exp_wr.size() != 0) begin
      miscompares++;
      $display("FAIL strided_end: got done=%b busy=%b pulses=%0d left=%0d/%0d, required 0 0 1 0/0",
               done, busy, done_cnt - d0, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_tail;
    int n;
    int d0 = done_cnt;
    kick(1'b0, 32'h1000, 32'd8, 32'h0, 32'h2000, 3);
    wait_done(50, n);
    @(posedge clk);
    #1;
    vectors++;
    if (n != 7 || done_cnt - d0 != 1 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL tail: got latency=%0d pulses=%0d left=%0d/%0d, required 7 1 0/0",
               n, done_cnt - d0, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_indirect;
    int n;
    kick(1'b1, 32'h4000, 32'h0, 32'h3000, 32'h2100, 2);
    vectors++;
    if (outState !== 4'd1 || cache_r_addr_o !== {32'h3004, 32'h3000}) begin
      miscompares++;
      $display("FAIL indirect_idx_req: got state=%0d addr=%h, required 1 / %h",
               outState, cache_r_addr_o, {32'h3004, 32'h3000});
    end
    wait_done(50, n);
    @(posedge clk);
    #1;
    vectors++;
    if (n != 6 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      miscompares++;
      $display("FAIL indirect: got latency=%0d left=%0d/%0d, required 6 0/0",
               n, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_backpressure;
    logic hit;
    wait_cache  = 1'b1;
    wait_strBuf = 1'b1;
    kick(1'b0, 32'h1000, 32'd8, 32'h0, 32'h2000, 2);
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (cache_data_req_o !== 1'b1 || cache_r_addr_o !== {32'h1008, 32'h1000}) begin
        miscompares++;
        $display("FAIL req_hold cycle %0d: got req=%b addr=%h, required 1 / %h",
                 k, cache_data_req_o, cache_r_addr_o, {32'h1008, 32'h1000});
      end
      if (k == 4) wait_cache = 1'b0;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (outState !== 4'd4 || cache_data_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL req_release: got state=%0d req=%b, required 4 0", outState, cache_data_req_o);
    end
    wait_state(4'd5, hit);
    for (int k = 0; k <= 2; k++) begin
      vectors++;
      if (!hit || strBufWren !== 2'b11 || w_addr_o !== {32'h2004, 32'h2000}
          || w_data_o !== {32'h1009, 32'h1001}) begin
        miscompares++;
        $display("FAIL wr_hold cycle %0d: got wren=%b addr=%h data=%h, required 11 %h %h",
                 k, strBufWren, w_addr_o, w_data_o, {32'h2004, 32'h2000}, {32'h1009, 32'h1001});
      end
      if (k == 2) wait_strBuf = 1'b0;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (done !== 1'b1 || strBufWren !== 2'b00 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL bp_end: got done=%b wren=%b left=%0d/%0d, required 1 00 0/0",
               done, strBufWren, exp_rd.size(), exp_wr.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap;
    int n;
    kick(1'b0, 32'h4, 32'hFFFF_FFFC, 32'h0, 32'h2000, 3);
    wait_done(50, n);
    @(posedge clk);
    #1;
    vectors++;
    if (n != 7 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      miscompares++;
      $display("FAIL wrap: got latency=%0d left=%0d/%0d, required 7 0/0",
               n, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_abort;
    logic hit;
    int   d0 = done_cnt;
    wait_strBuf = 1'b1;
    kick(1'b0, 32'h1000, 32'd8, 32'h0, 32'h2000, 2);
    wait_state(4'd5, hit);
    vectors++;
    if (!hit || strBufWren !== 2'b11) begin
      miscompares++;
      $display("FAIL abort_reach_write: got state=%0d wren=%b, required 5 11", outState, strBufWren);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    vectors++;
    if (outState !== 4'd0 || strBufWren !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got state=%0d wren=%b busy=%b done=%b, required 0 00 0 0",
               outState, strBufWren, busy, done);
    end
    exp_wr.delete();
    wait_strBuf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic hit;
    kick(1'b0, 32'h1000, 32'd8, 32'h0, 32'h2000, 2);
    wait_state(4'd4, hit);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (!hit || {cache_data_req_o, cache_r_addr_o, strBufWren, w_addr_o, w_data_o, busy, done,
                 outState} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got hit=%b req=%b wren=%b busy=%b state=%0d, required 1 0 00 0 0",
               hit, cache_data_req_o, strBufWren, busy, outState);
    end
    exp_rd.delete();
    exp_wr.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || cache_data_req_o !== 1'b0 || outState !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_no_restart: got busy=%b req=%b state=%0d, required 0 0 0",
               busy, cache_data_req_o, outState);
    end
  endtask

  task automatic test_count_zero;
    int d0 = done_cnt;
    kick(1'b0, 32'h1000, 32'd8, 32'h0, 32'h2000, 0);
    vectors++;
    if (done !== 1'b1 || cache_data_req_o !== 1'b0 || outState !== 4'd6) begin
      miscompares++;
      $display("FAIL count0_done: got done=%b req=%b state=%0d, required 1 0 6",
               done, cache_data_req_o, outState);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL count0_end: got done=%b busy=%b pulses=%0d, required 0 0 1",
               done, busy, done_cnt - d0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    trigger      = 1'b0;
    abort        = 1'b0;
    mode         = 1'b0;
    cfg_base     = '0;
    cfg_stride   = '0;
    cfg_idx_base = '0;
    cfg_dst      = '0;
    cfg_count    = '0;
    wait_cache   = 1'b0;
    wait_strBuf  = 1'b0;
    idx_tbl[0] = 32'd5;
    idx_tbl[1] = 32'd9;
    idx_tbl[2] = 32'd2;
    idx_tbl[3] = 32'd7;
    idx_tbl[4] = 32'd1;
    idx_tbl[5] = 32'd3;
    idx_tbl[6] = 32'd4;
    idx_tbl[7] = 32'd6;
    test_reset;
    test_strided;
    test_tail;
    test_indirect;
    test_backpressure;
    test_wrap;
    test_abort;
    test_reset_mid;
    test_count_zero;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
